rom_loader_wb: RTL and testbench
================================

Name: rom_loader_wb

Overview:
- Converts the HPS 16-bit ioctl download stream for the RISC OS ROM image into 32-bit Wishbone write cycles towards the SDRAM controller.
- Sits between hps_io (ioctl_*) and the SDRAM Wishbone port. While owns_bus is high, the top-level mux selects this block's Wishbone signals.
- Packs halfwords into words and back-pressures the HPS with ioctl_wait.
- Reports completion, word count and ack-timeout errors.

Parameters:
- ROM_INDEX, 8'd1, ioctl_index value that selects this loader.
- BASE_ADDR, 26'h0400000, SDRAM byte address of ioctl_addr 0.
- ACK_TIMEOUT, 255, clk_sys cycles to wait for wb_ack before flagging an error.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download active
- ioctl_index  in  8  download target index
- ioctl_wr  in  1  one-cycle halfword strobe
- ioctl_addr  in  25  byte address of halfword (bit 0 ignored)
- ioctl_dout  in  16  halfword data
- ioctl_wait  out  1  hold off next ioctl_wr
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  always 1 while wb_cyc is high
- wb_sel  out  4  byte enables
- wb_adr  out  26  byte address, [1:0] = 0
- wb_dat_o  out  32  write data
- wb_ack  in  1  Wishbone ack
- owns_bus  out  1  active = ioctl_download & (ioctl_index == ROM_INDEX)
- done  out  1  one-cycle pulse when the last word is acked after download end
- err  out  1  sticky ack-timeout flag
- words_written  out  22  count of acked Wishbone writes

Behaviour:
- Reset: all outputs are 0, both buffers are cleared, the FSM is in IDLE, and the counters are 0. A reset mid-cycle drops wb_cyc and wb_stb immediately; no ack is expected afterwards.
- Start: on the rising edge of active, clear err and words_written and both buffers.
- Buffers:
  - A is the assembly buffer: valid, word address, 32-bit data, 4-bit mask.
  - W is the write buffer: valid, address, data, sel.
- ioctl_wait = A.valid & W.valid. This is combinational from registers, so it is high in the cycle after the ioctl_wr that created the condition.
- Invariant: an ioctl_wr never arrives while A.valid & W.valid.
- Halfword placement:
  - ioctl_addr[1] = 0 puts the halfword in data[15:0] with mask 0011.
  - ioctl_addr[1] = 1 puts the halfword in data[31:16] with mask 1100.
  - Word address = BASE_ADDR + {ioctl_addr[23:2], 2'b00}.
- ioctl_wr while active:
  - A empty: load A.
  - A valid, same word: OR the mask in and merge the data. A repeated half overwrites the data; the mask is unchanged.
  - A valid, different word: move A to W as a partial write (sel = A.mask), then load the new half into A.
- A becomes full (mask 1111) and W empty: move A to W in the next cycle and clear A.
- End of download (falling edge of active, or ioctl_index change while downloading): a valid partial A is flushed to W with its mask as soon as W empties.
- Wishbone FSM:
  - IDLE: if W.valid, go to REQ with wb_cyc = wb_stb = 1 and address/data/sel from W.
  - REQ, wb_ack: drop cyc/stb, clear W, increment words_written (saturating at 2^22-1), return to IDLE.
  - REQ, timer reaches ACK_TIMEOUT with no ack: go to ERR, set err, drop cyc/stb, clear W.
  - ERR: ioctl_wait stays 0; further writes are discarded. Leave ERR only on the next start.
- done: one-cycle pulse when ~active and A and W are both empty and the FSM is IDLE, after a download during which at least one ioctl_wr was received. It fires once per download.
- When ioctl_index != ROM_INDEX, ioctl_wr is ignored and owns_bus stays 0.
- Simultaneous events:
  - wb_ack and the move of A to W in the same cycle: the new W load wins; the count still increments.
  - ioctl_wr on the same cycle as a full-A move: impossible by the invariant.

Decomposition:
- Package rom_loader_pkg holds:
  - localparams for the half masks (MASK_LO = 4'b0011, MASK_HI = 4'b1100, MASK_FULL = 4'b1111);
  - the FSM enum {IDLE, REQ, ERR};
  - the half_t struct (addr, data, mask).
- Sub-module: wb_single_writer contains the W buffer, the IDLE/REQ/ERR FSM and the timeout counter. The packing logic stays in the top module.

Test Plan:
- Sequential halfwords at addr 0, 2 (data 1234, 5678): one write, wb_adr = 26'h0400000, wb_sel = 1111, wb_dat_o = 5678_1234; words_written = 1; done pulses once after download drops.
- Reverse order, addr 6 then 4: single write to 26'h0400004 with sel 1111 and correct data; no partial write issued.
- Lone halfword at addr 0x0A, then download ends: write to 26'h0400008 with sel 1100 and data in [31:16]; done follows.
- Slow slave (ack after 20 cycles) with 8 back-to-back halfwords at 4-cycle spacing: ioctl_wait rises; no data is lost; 4 writes in address order; words_written = 4.
- No ack at all: err rises at cycle ACK_TIMEOUT+1 after stb; wb_cyc drops; later writes are ignored; a new download clears err.
- ioctl_index = 3 with writes: no Wishbone activity; owns_bus = 0. Reset asserted during REQ: cyc/stb low the next cycle and all outputs at reset values.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the RISC OS ROM loader: halfword lane masks,
// Wishbone writer states and the buffered-word record.
package rom_loader_pkg;

  localparam logic [3:0] MASK_LO   = 4'b0011;
  localparam logic [3:0] MASK_HI   = 4'b1100;
  localparam logic [3:0] MASK_FULL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ERR
  } wb_state_t;

  typedef struct packed {
    logic [25:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } half_t;

endpackage

// File: rtl/wb_single_writer.sv
// Single-entry write buffer feeding one Wishbone write at a time, with an
// ack timeout that parks the writer in ERR until the next download starts.
module wb_single_writer
  import rom_loader_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        load,
  input  half_t       load_half,
  output logic        w_valid,
  output logic        w_ready,
  output logic        idle,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [25:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack,
  output logic        err,
  output logic [21:0] words_written
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  wb_state_t   state_reg, state_next;
  logic [TW-1:0] timer_reg;
  half_t       w_reg;
  logic        w_valid_reg;
  logic        err_reg;
  logic [21:0] words_reg;
  logic        ack_accept;
  logic        timeout;
  logic        in_req;

  always_comb begin
    state_next = state_reg;
    ack_accept = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: if (w_valid_reg) state_next = REQ;
      REQ: begin
        if (wb_ack) begin
          state_next = IDLE;
          ack_accept = 1'b1;
        end else if (timer_reg == TW'(ACK_TIMEOUT)) begin
          state_next = ERR;
          timeout    = 1'b1;
        end
      end
      ERR: state_next = ERR;
      default: state_next = IDLE;
    endcase
    // A new download always restarts the writer, including out of ERR.
    if (start) state_next = IDLE;
  end

  // An ack frees the buffer in the same cycle, so a new word may be loaded then.
  assign w_ready = !w_valid_reg || ack_accept;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      w_reg       <= '0;
      w_valid_reg <= 1'b0;
      err_reg     <= 1'b0;
      words_reg   <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= (state_reg == REQ && state_next == REQ) ? timer_reg + 1'b1 : '0;
      if (start) begin
        w_valid_reg <= 1'b0;
        err_reg     <= 1'b0;
        words_reg   <= '0;
      end else begin
        if (load && w_ready && state_reg != ERR) begin
          w_reg       <= load_half;
          w_valid_reg <= 1'b1;
        end else if (ack_accept || timeout) begin
          w_valid_reg <= 1'b0;
        end
        if (timeout) err_reg <= 1'b1;
        if (ack_accept && words_reg != '1) words_reg <= words_reg + 1'b1;
      end
    end
  end

  assign in_req        = (state_reg == REQ);
  assign wb_cyc        = in_req;
  assign wb_stb        = in_req;
  assign wb_we         = in_req;
  assign wb_sel        = in_req ? w_reg.mask : 4'b0000;
  assign wb_adr        = in_req ? w_reg.addr : 26'd0;
  assign wb_dat_o      = in_req ? w_reg.data : 32'd0;
  assign w_valid       = w_valid_reg;
  assign idle          = (state_reg == IDLE);
  assign err           = err_reg;
  assign words_written = words_reg;

endmodule

// File: rtl/rom_loader_wb.sv
// Packs the HPS 16-bit ioctl ROM download into 32-bit Wishbone writes,
// back-pressuring the HPS while both the assembly and write buffers are full.
module rom_loader_wb
  import rom_loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX   = 8'd1,
  parameter logic [25:0] BASE_ADDR   = 26'h0400000,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [25:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack,
  output logic        owns_bus,
  output logic        done,
  output logic        err,
  output logic [21:0] words_written
);

  logic        active;
  logic        active_prev_reg;
  logic        start;
  logic        wr_ok;
  half_t       a_reg, a_next;
  logic        a_valid_reg, a_valid_next;
  logic        got_wr_reg, got_wr_next;
  logic        done_reg, done_next;
  half_t       in_half;
  logic        w_load;
  logic        w_valid;
  logic        w_ready;
  logic        w_idle;
  logic        unused_addr_bits;

  assign active = ioctl_download && (ioctl_index == ROM_INDEX);
  assign start  = active && !active_prev_reg;
  assign wr_ok  = ioctl_wr && active && !err;

  // Bit 0 selects a byte inside the halfword and bit 24 lies beyond the ROM window.
  assign unused_addr_bits = ^{ioctl_addr[24], ioctl_addr[0]};

  always_comb begin
    in_half.addr = BASE_ADDR + {2'b00, ioctl_addr[23:2], 2'b00};
    in_half.mask = ioctl_addr[1] ? MASK_HI : MASK_LO;
    in_half.data = ioctl_addr[1] ? {ioctl_dout, 16'h0000} : {16'h0000, ioctl_dout};

    a_next       = a_reg;
    a_valid_next = a_valid_reg && !start;
    got_wr_next  = got_wr_reg && !start;
    w_load       = 1'b0;

    if (wr_ok) begin
      got_wr_next = 1'b1;
      if (a_valid_next && a_reg.addr == in_half.addr) begin
        a_next.mask = a_reg.mask | in_half.mask;
        if (ioctl_addr[1]) a_next.data[31:16] = ioctl_dout;
        else               a_next.data[15:0]  = ioctl_dout;
      end else begin
        // A different word retires the current assembly as a partial write.
        w_load       = a_valid_next;
        a_next       = in_half;
        a_valid_next = 1'b1;
      end
    end else if (a_valid_next && (a_reg.mask == MASK_FULL || !active) && w_ready) begin
      w_load       = 1'b1;
      a_valid_next = 1'b0;
    end

    done_next = !active && got_wr_reg && !a_valid_reg && !w_valid && w_idle;
    if (done_next) got_wr_next = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      active_prev_reg <= 1'b0;
      a_reg           <= '0;
      a_valid_reg     <= 1'b0;
      got_wr_reg      <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      active_prev_reg <= active;
      a_reg           <= a_next;
      a_valid_reg     <= a_valid_next;
      got_wr_reg      <= got_wr_next;
      done_reg        <= done_next;
    end
  end

  wb_single_writer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_writer (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .start         (start),
    .load          (w_load),
    .load_half     (a_reg),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .idle          (w_idle),
    .wb_cyc        (wb_cyc),
    .wb_stb        (wb_stb),
    .wb_we         (wb_we),
    .wb_sel        (wb_sel),
    .wb_adr        (wb_adr),
    .wb_dat_o      (wb_dat_o),
    .wb_ack        (wb_ack),
    .err           (err),
    .words_written (words_written)
  );

  assign ioctl_wait = a_valid_reg && w_valid;
  assign owns_bus   = active && !reset;
  assign done       = done_reg;

endmodule

// File: tb/tb_rom_loader_wb.sv
// Randomised and directed bench for rom_loader_wb: a word-level packing model
// predicts each Wishbone write; a per-cycle monitor plays the slave and checks.
module tb_rom_loader_wb;

  localparam int          ACK_TIMEOUT = 255;
  localparam logic [25:0] BASE        = 26'h0400000;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [25:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic        wb_ack = 1'b0;
  logic        owns_bus, done, err;
  logic [21:0] words_written;

  rom_loader_wb #(
    .ROM_INDEX   (8'd1),
    .BASE_ADDR   (BASE),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .wb_cyc         (wb_cyc),
    .wb_stb         (wb_stb),
    .wb_we          (wb_we),
    .wb_sel         (wb_sel),
    .wb_adr         (wb_adr),
    .wb_dat_o       (wb_dat_o),
    .wb_ack         (wb_ack),
    .owns_bus       (owns_bus),
    .done           (done),
    .err            (err),
    .words_written  (words_written)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [25:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_t;

  int   n_checks = 0;
  int   n_fail = 0;
  wr_t  exp_q[$];
  logic [25:0] adr_log[$];
  wr_t  last_wr;
  int   model_count = 0;
  int   done_cnt = 0;
  int   cyc_cycles = 0;
  int   wait_cnt = 0;
  int   lat_cnt = 0;
  int   lat_target = 0;
  int   lat_fixed = -1;
  bit   no_ack = 1'b0;
  bit   prev_act = 1'b0;
  bit   exp_accept = 1'b1;
  int   exp_total = 0;

  // Word-level packing model: the word currently being assembled.
  bit          m_valid = 1'b0;
  logic [25:0] m_word;
  logic [31:0] m_data;
  logic [3:0]  m_mask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Monitor and Wishbone slave, sampled mid-cycle on the falling edge.
  always @(negedge clk_sys) begin : monitor
    bit  act_now;
    wr_t e;
    act_now = ioctl_download && (ioctl_index == 8'd1);
    check("owns_bus", owns_bus, act_now && !reset);
    check("stb_we_follow_cyc", {wb_stb, wb_we}, {wb_cyc, wb_cyc});
    check("words_written", words_written, model_count);
    if (wb_cyc) check("adr_aligned", wb_adr[1:0], 2'b00);
    if (done) begin
      done_cnt++;
      check("done_while_active", act_now, 1'b0);
    end
    if (err) check("wait_in_err", ioctl_wait, 1'b0);
    if (ioctl_wait) wait_cnt++;
    if (wb_cyc) cyc_cycles++;

    if (wb_ack) begin
      wb_ack = 1'b0;
    end else if (wb_cyc && !reset) begin
      if (lat_cnt == 0) begin
        check("cyc_has_pending_write", exp_q.size() != 0, 1'b1);
        lat_target = (lat_fixed >= 0) ? lat_fixed :
                     (($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 6));
      end
      if (!no_ack && lat_cnt >= lat_target) begin
        wb_ack = 1'b1;
        if (exp_q.size() == 0) check("write_expected", 0, 1);
        else begin
          e = exp_q.pop_front();
          check("wb_write", {wb_adr, wb_sel, wb_dat_o & lanes(wb_sel)},
                            {e.adr, e.sel, e.dat & lanes(e.sel)});
        end
        last_wr = {wb_adr, wb_sel, wb_dat_o};
        adr_log.push_back(wb_adr);
        model_count++;
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
    if (reset || (act_now && !prev_act)) model_count = 0;
    prev_act = act_now;
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic push_model();
    exp_q.push_back({m_word, m_mask, m_data});
    exp_total++;
    m_valid = 1'b0;
  endtask

  task automatic model_hw(input logic [24:0] addr, input logic [15:0] data);
    logic [25:0] word;
    word = BASE + {2'b00, addr[23:2], 2'b00};
    if (m_valid && m_word != word) push_model();
    if (!m_valid) begin
      m_valid = 1'b1;
      m_word  = word;
      m_data  = '0;
      m_mask  = '0;
    end
    if (addr[1]) begin
      m_data[31:16] = data;
      m_mask = m_mask | 4'b1100;
    end else begin
      m_data[15:0] = data;
      m_mask = m_mask | 4'b0011;
    end
    if (m_mask == 4'b1111) push_model();
  endtask

  task automatic send_hw(input logic [24:0] addr, input logic [15:0] data);
    int guard;
    guard = 0;
    while (ioctl_wait && guard < 1000) begin
      tick(1);
      guard++;
    end
    if (guard >= 1000) check("wait_release_timeout", ioctl_wait, 1'b0);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    if (exp_accept) model_hw(addr, data);
    tick(1);
    ioctl_wr = 1'b0;
    tick(1);
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    m_valid        = 1'b0;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(2);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    if (exp_accept && m_valid) push_model();
    m_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || wb_cyc) && g < max) begin
      tick(1);
      g++;
    end
    if (g >= max) check("drain_timeout", exp_q.size(), 0);
    tick(4);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, l0, w0, c0, e0, g, n;
    tick(3);
    check("reset_cyc", {wb_cyc, wb_stb, wb_we}, 3'b000);
    check("reset_bus", {wb_sel, wb_adr, wb_dat_o}, 62'd0);
    check("reset_flags", {ioctl_wait, owns_bus, done, err}, 4'b0000);
    check("reset_words", words_written, 0);
    reset = 1'b0;
    tick(2);

    // Sequential halves 0,2
    d0 = done_cnt; l0 = adr_log.size(); lat_fixed = 2;
    begin_dl(8'd1);
    send_hw(25'h0, 16'h1234);
    send_hw(25'h2, 16'h5678);
    end_dl();
    drain(500);
    check("t1_adr", last_wr.adr, 26'h0400000);
    check("t1_sel", last_wr.sel, 4'b1111);
    check("t1_dat", last_wr.dat, 32'h5678_1234);
    check("t1_nwrites", adr_log.size() - l0, 1);
    check("t1_words", words_written, 1);
    check("t1_done", done_cnt - d0, 1);

    // Reverse order 6 then 4
    d0 = done_cnt; l0 = adr_log.size();
    begin_dl(8'd1);
    send_hw(25'h6, 16'hBBBB);
    send_hw(25'h4, 16'hAAAA);
    end_dl();
    drain(500);
    check("t2_write", {last_wr.adr, last_wr.sel, last_wr.dat}, {26'h0400004, 4'b1111, 32'hBBBB_AAAA});
    check("t2_nwrites", adr_log.size() - l0, 1);
    check("t2_done", done_cnt - d0, 1);

    // Lone high half at 0x0A
    d0 = done_cnt;
    begin_dl(8'd1);
    send_hw(25'hA, 16'hCAFE);
    end_dl();
    drain(500);
    check("t3_adr_sel", {last_wr.adr, last_wr.sel}, {26'h0400008, 4'b1100});
    check("t3_dat_hi", last_wr.dat[31:16], 16'hCAFE);
    check("t3_done", done_cnt - d0, 1);

    // Slow slave, 8 halves at 4-cycle spacing
    d0 = done_cnt; l0 = adr_log.size(); w0 = wait_cnt; lat_fixed = 20;
    begin_dl(8'd1);
    for (int i = 0; i < 8; i++) begin
      send_hw(25'(2 * i), 16'(16'h1000 + i));
      tick(2);
    end
    end_dl();
    drain(2000);
    check("t4_wait_rose", wait_cnt > w0, 1'b1);
    check("t4_nwrites", adr_log.size() - l0, 4);
    for (int i = 0; i < 4 && l0 + i < adr_log.size(); i++)
      check("t4_order", adr_log[l0 + i], 26'h0400000 + 26'(4 * i));
    check("t4_words", words_written, 4);
    check("t4_done", done_cnt - d0, 1);

    // Randomised downloads
    lat_fixed = -1;
    for (int dl = 0; dl < 4; dl++) begin
      int wd;
      d0 = done_cnt; e0 = exp_total;
      wd = $urandom_range(0, 4000);
      begin_dl(8'd1);
      for (int i = 0; i < 10; i++) begin
        int r;
        bit hi_first;
        logic [24:0] a0;
        r = $urandom_range(0, 9);
        hi_first = 1'($urandom_range(0, 1));
        a0 = 25'(wd * 4);
        if (r < 6) begin
          send_hw(a0 + (hi_first ? 25'd2 : 25'd0), 16'($urandom));
          send_hw(a0 + (hi_first ? 25'd0 : 25'd2), 16'($urandom));
        end else if (r < 8) begin
          send_hw(a0 + (hi_first ? 25'd2 : 25'd0), 16'($urandom));
        end else begin
          send_hw(a0 + (hi_first ? 25'd2 : 25'd0), 16'($urandom));
          send_hw(a0 + (hi_first ? 25'd2 : 25'd0), 16'($urandom));
        end
        tick($urandom_range(0, 2));
        wd = wd + $urandom_range(1, 3);
      end
      end_dl();
      drain(3000);
      check("rand_words", words_written, exp_total - e0);
      check("rand_done", done_cnt - d0, 1);
    end

    // Ack timeout
    no_ack = 1'b1; d0 = done_cnt;
    begin_dl(8'd1);
    send_hw(25'h0, 16'h1111);
    send_hw(25'h2, 16'h2222);
    g = 0;
    while (!wb_cyc && g < 50) begin tick(1); g++; end
    check("t5_cyc_started", wb_cyc, 1'b1);
    n = 0;
    while (!err && n < 1000) begin tick(1); n++; end
    check("t5_timeout_cycle", n, ACK_TIMEOUT + 1);
    check("t5_cyc_dropped", {wb_cyc, wb_stb}, 2'b00);
    exp_q.delete();
    exp_accept = 1'b0;
    c0 = cyc_cycles;
    send_hw(25'h4, 16'h3333);
    send_hw(25'h6, 16'h4444);
    tick(10);
    check("t5_ignored", cyc_cycles - c0, 0);
    check("t5_err_sticky", err, 1'b1);
    check("t5_words", words_written, 0);
    end_dl();
    tick(3);
    exp_accept = 1'b1; no_ack = 1'b0;
    begin_dl(8'd1);
    check("t5_err_cleared", err, 1'b0);
    end_dl();
    tick(5);
    check("t5_no_done", done_cnt - d0, 0);

    // Foreign index
    d0 = done_cnt; c0 = cyc_cycles; exp_accept = 1'b0;
    begin_dl(8'd3);
    send_hw(25'h0, 16'h5555);
    send_hw(25'h2, 16'h6666);
    check("t6_owns_bus", owns_bus, 1'b0);
    end_dl();
    tick(10);
    check("t6_no_cyc", cyc_cycles - c0, 0);
    check("t6_no_done", done_cnt - d0, 0);
    exp_accept = 1'b1;

    // Reset during REQ
    no_ack = 1'b1; d0 = done_cnt;
    begin_dl(8'd1);
    send_hw(25'h10, 16'h7777);
    send_hw(25'h12, 16'h8888);
    g = 0;
    while (!wb_cyc && g < 50) begin tick(1); g++; end
    check("t7_in_req", wb_cyc, 1'b1);
    reset = 1'b1;
    tick(1);
    check("t7_cyc_dropped", {wb_cyc, wb_stb, wb_we}, 3'b000);
    check("t7_outputs", {ioctl_wait, owns_bus, done, err, wb_sel}, 8'h00);
    check("t7_words", words_written, 0);
    exp_q.delete();
    reset = 1'b0; no_ack = 1'b0;
    ioctl_download = 1'b0;
    tick(5);
    check("t7_no_done", done_cnt - d0, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
